// File: rtl/unary_divide_const.sv
// Streaming unary divider: emits an INPUT_WIDTH-bit unary frame y with ones(y) ~= ones(a)/DIVISOR,
// bit-serially while a is still arriving. Macro UNARY_DIV_BOUNDS_DEBUG_EN exposes counters and bounds.
module unary_divide_const #(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned DIVISOR     = 2,
  parameter int unsigned EPSILON     = 0,
  parameter int unsigned COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a,
  input  logic a_valid,
  output logic a_ready,
  output logic y,
  output logic y_valid,
  input  logic y_ready,
  output logic done
`ifdef UNARY_DIV_BOUNDS_DEBUG_EN
  ,
  output logic [COUNT_WIDTH-1:0]                 dbg_a_ones,
  output logic [COUNT_WIDTH-1:0]                 dbg_a_count,
  output logic [COUNT_WIDTH-1:0]                 dbg_y_ones,
  output logic [COUNT_WIDTH-1:0]                 dbg_y_count,
  output logic [COUNT_WIDTH+$clog2(DIVISOR)+1:0] dbg_l,
  output logic [COUNT_WIDTH+$clog2(DIVISOR)+1:0] dbg_u,
  output logic [COUNT_WIDTH+$clog2(DIVISOR)+1:0] dbg_m
`endif
);

  localparam int unsigned BW   = COUNT_WIDTH + $clog2(DIVISOR) + 2;
  localparam int unsigned MAXV = 2 * DIVISOR * INPUT_WIDTH;
  localparam logic [BW-1:0] MAX_B = BW'(MAXV);
  // Saturating EPSILON at MAXV gives the same Mp/Mm results and keeps M+EPS inside BW bits.
  localparam logic [BW-1:0] EPS_B = BW'((EPSILON < MAXV) ? EPSILON : MAXV);
  localparam logic [BW-1:0] DIV_B = BW'(DIVISOR);
  localparam logic [BW-1:0] W_B   = BW'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] W_C   = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;
  logic [COUNT_WIDTH-1:0] a_count_q, a_count_d, a_ones_q, a_ones_d;
  logic [COUNT_WIDTH-1:0] y_count_q, y_count_d, y_ones_q, y_ones_d;
  logic y_q, y_d, y_valid_q, y_valid_d;

  logic [BW-1:0] bound_l, bound_u, mid, mid_eps, mid_p, mid_m, d_lo, d_hi;
  logic dec_fire, dec_bit, slot_free, commit, a_take, last_take;

  always_comb begin
    bound_l = BW'(a_ones_q) << 1;
    bound_u = (BW'(a_ones_q) + W_B - BW'(a_count_q)) << 1;
    mid     = DIV_B * ((BW'(y_ones_q) << 1) + W_B - BW'(y_count_q));
    mid_eps = mid + EPS_B;
    mid_p   = (mid_eps > MAX_B) ? MAX_B : mid_eps;
    mid_m   = (EPS_B >= mid) ? '0 : mid - EPS_B;
    d_hi    = bound_u - mid;
    d_lo    = mid - bound_l;
  end

  always_comb begin
    dec_fire = 1'b0;
    dec_bit  = 1'b0;
    if (mid <= bound_l) begin
      dec_fire = 1'b1;
      dec_bit  = 1'b1;
    end else if (mid >= bound_u) begin
      dec_fire = 1'b1;
    end else if (mid_m <= bound_l && mid_p < bound_u) begin
      dec_fire = 1'b1;
      dec_bit  = 1'b1;
    end else if (mid_p >= bound_u && mid_m > bound_l) begin
      dec_fire = 1'b1;
    end else if (mid_m <= bound_l && mid_p >= bound_u) begin
      dec_fire = 1'b1;
      dec_bit  = (d_lo <= d_hi);
    end
  end

  always_comb begin
    slot_free = !y_valid_q || y_ready;
    commit    = (state_q == RUN) && (a_count_q != '0) && (y_count_q < W_C) && slot_free && dec_fire;
    a_take    = a_valid && a_ready;
    last_take = y_valid_q && y_ready && (y_count_q == W_C);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (last_take) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    a_ready = (state_q == RUN) && (a_count_q < W_C);
    done    = (state_q == DONE);
  end

  always_comb begin
    a_count_d = a_count_q;
    a_ones_d  = a_ones_q;
    y_count_d = y_count_q;
    y_ones_d  = y_ones_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (start) begin
      a_count_d = '0;
      a_ones_d  = '0;
      y_count_d = '0;
      y_ones_d  = '0;
      y_valid_d = 1'b0;
    end else begin
      if (a_take) begin
        a_count_d = a_count_q + ONE_C;
        a_ones_d  = a_ones_q + COUNT_WIDTH'(a);
      end
      // A consumed bit with no fresh decision leaves the output slot empty.
      if (commit) begin
        y_d       = dec_bit;
        y_valid_d = 1'b1;
        y_count_d = y_count_q + ONE_C;
        y_ones_d  = y_ones_q + COUNT_WIDTH'(dec_bit);
      end else if (y_ready) begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_count_q <= '0;
      a_ones_q  <= '0;
      y_count_q <= '0;
      y_ones_q  <= '0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      a_count_q <= a_count_d;
      a_ones_q  <= a_ones_d;
      y_count_q <= y_count_d;
      y_ones_q  <= y_ones_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  always_comb begin
    y       = y_q;
    y_valid = y_valid_q;
  end

`ifdef UNARY_DIV_BOUNDS_DEBUG_EN
  always_comb begin
    dbg_a_ones  = a_ones_q;
    dbg_a_count = a_count_q;
    dbg_y_ones  = y_ones_q;
    dbg_y_count = y_count_q;
    dbg_l       = bound_l;
    dbg_u       = bound_u;
    dbg_m       = mid;
  end
`endif

endmodule

// File: tb/tb_unary_divide_const.sv
// Scoreboard bench for unary_divide_const: four parameterisations driven in parallel against a
// cycle-level arithmetic reference model; expected y bits are queued and checked on each handshake.
module tb_unary_divide_const;

  localparam int NI = 4;
  localparam int PW [NI] = '{8, 8, 8, 12};
  localparam int PD [NI] = '{2, 4, 1, 3};
  localparam int PE [NI] = '{0, 0, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NI-1:0] start, a, a_valid, y_ready;
  logic [NI-1:0] a_ready, y, y_valid, done;

  unary_divide_const #(.INPUT_WIDTH(8), .DIVISOR(2), .EPSILON(0)) u_w8_d2 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a[0]), .a_valid(a_valid[0]), .a_ready(a_ready[0]),
    .y(y[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0]), .done(done[0]));
  unary_divide_const #(.INPUT_WIDTH(8), .DIVISOR(4), .EPSILON(0)) u_w8_d4 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a[1]), .a_valid(a_valid[1]), .a_ready(a_ready[1]),
    .y(y[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1]), .done(done[1]));
  unary_divide_const #(.INPUT_WIDTH(8), .DIVISOR(1), .EPSILON(2)) u_w8_d1_e2 (
    .clk(clk), .reset(reset), .start(start[2]), .a(a[2]), .a_valid(a_valid[2]), .a_ready(a_ready[2]),
    .y(y[2]), .y_valid(y_valid[2]), .y_ready(y_ready[2]), .done(done[2]));
  unary_divide_const #(.INPUT_WIDTH(12), .DIVISOR(3), .EPSILON(3)) u_w12_d3_e3 (
    .clk(clk), .reset(reset), .start(start[3]), .a(a[3]), .a_valid(a_valid[3]), .a_ready(a_ready[3]),
    .y(y[3]), .y_valid(y_valid[3]), .y_ready(y_ready[3]), .done(done[3]));

  int total = 0;
  int bad   = 0;

  // Reference model state (post-edge view of each instance)
  int ac [NI], ao [NI], yc [NI], yo [NI];
  bit run_m [NI], done_m [NI], yv_m [NI], yb_m [NI];
  int exp_q [NI][$];

  // Monitor bookkeeping per frame
  int hs [NI], ones [NI], last_ones [NI];
  bit fchk [NI];

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Returns 1 or 0 for a decision, 2 when the bounds allow none.
  function automatic int decide(input int i);
    int w, d, e, l, u, m, mp, mm;
    w  = PW[i];
    d  = PD[i];
    e  = PE[i];
    l  = 2 * ao[i];
    u  = 2 * (ao[i] + w - ac[i]);
    m  = d * (2 * yo[i] + w - yc[i]);
    mp = (m + e < 2 * d * w) ? m + e : 2 * d * w;
    mm = (e >= m) ? 0 : m - e;
    if (m <= l) return 1;
    if (m >= u) return 0;
    if (mm <= l && mp < u) return 1;
    if (mp >= u && mm > l) return 0;
    if (mm <= l && mp >= u) return (m - l <= u - m) ? 1 : 0;
    return 2;
  endfunction

  // Model: advances on each active edge using the inputs the driver holds for that cycle.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      bit acc, last, allowed;
      int dd;
      acc     = a_valid[i] && run_m[i] && (ac[i] < PW[i]);
      last    = yv_m[i] && y_ready[i] && (yc[i] == PW[i]);
      allowed = (ac[i] != 0) && (yc[i] < PW[i]) && (!yv_m[i] || y_ready[i]);
      dd      = decide(i);
      if (reset) begin
        ac[i] = 0; ao[i] = 0; yc[i] = 0; yo[i] = 0;
        run_m[i] = 0; done_m[i] = 0; yv_m[i] = 0; yb_m[i] = 0;
        exp_q[i].delete();
      end else if (start[i]) begin
        ac[i] = 0; ao[i] = 0; yc[i] = 0; yo[i] = 0;
        run_m[i] = 1; done_m[i] = 0; yv_m[i] = 0;
        exp_q[i].delete();
      end else if (run_m[i]) begin
        if (allowed && dd != 2) begin
          yb_m[i] = (dd == 1);
          yv_m[i] = 1;
          yc[i]++;
          yo[i] += dd;
          exp_q[i].push_back(dd);
        end else if (y_ready[i]) begin
          yv_m[i] = 0;
        end
        if (last) begin
          run_m[i]  = 0;
          done_m[i] = 1;
        end
        if (acc) begin
          ac[i]++;
          ao[i] += int'(a[i]);
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every y handshake.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("a_ready", i, int'(a_ready[i]), int'(run_m[i] && ac[i] < PW[i]));
      chk("y_valid", i, int'(y_valid[i]), int'(yv_m[i]));
      chk("done", i, int'(done[i]), int'(done_m[i]));
      chk("y_level", i, int'(y[i]), int'(yb_m[i]));
      if (y_valid[i] && y_ready[i]) begin
        if (exp_q[i].size() == 0) chk("sb_nonempty", i, int'(exp_q[i].size() > 0), 1);
        else chk("y_sb", i, int'(y[i]), exp_q[i].pop_front());
        hs[i]++;
        ones[i] += int'(y[i]);
      end
      if (done_m[i] && !fchk[i]) begin
        int diff;
        fchk[i] = 1;
        chk("handshakes", i, hs[i], PW[i]);
        if (PE[i] == 0 && ac[i] == PW[i]) begin
          diff = PD[i] * ones[i] - ao[i];
          if (diff < 0) diff = -diff;
          chk("accuracy", i, int'(diff <= PD[i]), 1);
        end
        last_ones[i] = ones[i];
      end
      if (reset || start[i]) begin
        hs[i]   = 0;
        ones[i] = 0;
        fchk[i] = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // amode: 0 zeros, 1 ones, 2 random; vmode: 0 always valid, 1 random;
  // rmode: 0 always ready, 1 random, 2 ready dropped for 5 cycles mid-frame.
  task automatic do_frame(input int amode, input int vmode, input int rmode);
    int n;
    bit all;
    start = '1;
    cyc();
    start = '0;
    n   = 0;
    all = 0;
    while (!all && n < 400) begin
      for (int i = 0; i < NI; i++) begin
        a[i]       = (amode == 0) ? 1'b0 : (amode == 1) ? 1'b1 : 1'($urandom_range(1));
        a_valid[i] = (vmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        y_ready[i] = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(2) != 0) : !(n >= 3 && n < 8);
      end
      cyc();
      n++;
      all = 1;
      for (int i = 0; i < NI; i++) if (!done_m[i]) all = 0;
    end
    chk("frame_complete", 0, int'(all), 1);
    a_valid = '0;
    y_ready = '1;
    repeat (2) cyc();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = '0;
    a = '0;
    a_valid = '0;
    y_ready = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    for (int i = 0; i < NI; i++)
      chk("reset_outs", i, int'({a_ready[i], y[i], y_valid[i], done[i]}), 0);

    do_frame(1, 0, 0);
    chk("ones_all1_d2", 0, last_ones[0], 4);
    chk("ones_all1_d4", 1, last_ones[1], 2);
    chk("a_ready_after_done", 0, int'(a_ready[0]), 0);

    do_frame(0, 0, 0);
    chk("ones_all0_d4", 1, last_ones[1], 0);

    do_frame(2, 0, 2);

    // Abort a frame after three accepted y bits.
    start = '1;
    cyc();
    start = '0;
    n = 0;
    while (hs[0] < 3 && n < 100) begin
      for (int i = 0; i < NI; i++) a[i] = 1'($urandom_range(1));
      a_valid = '1;
      y_ready = '1;
      cyc();
      n++;
    end
    chk("abort_reached", 0, int'(hs[0] >= 3), 1);
    start = '1;
    cyc();
    start = '0;
    a_valid = '0;
    for (int i = 0; i < NI; i++) begin
      chk("abort_y_valid", i, int'(y_valid[i]), 0);
      chk("abort_done", i, int'(done[i]), 0);
    end
    do_frame(2, 1, 1);

    // Reset in the middle of a frame.
    start = '1;
    cyc();
    start = '0;
    a_valid = '1;
    y_ready = '1;
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < NI; i++)
      chk("reset_mid_outs", i, int'({a_ready[i], y[i], y_valid[i], done[i]}), 0);
    repeat (3) cyc();
    for (int i = 0; i < NI; i++) chk("idle_no_y_valid", i, int'(y_valid[i]), 0);
    a_valid = '0;

    for (int f = 0; f < 40; f++)
      do_frame(($urandom_range(3) == 0) ? int'($urandom_range(1)) : 2, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
